// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB completer types, decode widths and register offsets
package apb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    localparam int APB_DEC_W   = 12;
    localparam int APB_IDX_LSB = 2;
    localparam int APB_IDX_W   = APB_DEC_W - APB_IDX_LSB;
    localparam int APB_CNT_W   = 4;

    localparam logic [31:0]          APB_ID_DEFAULT = 32'hA5B0_0001;
    localparam logic [APB_DEC_W-1:0] REG_CTRL       = 12'h000;

    // The ID register always sits in the last word of the bank.
    function automatic logic [APB_DEC_W-1:0] reg_id_offset(input int num_regs);
        return APB_DEC_W'(4 * (num_regs - 1));
    endfunction

endpackage

// File: rtl/apb_regbank.sv
// rtl/apb_regbank.sv - writable register array with async read mux and constant ID word
module apb_regbank
    import apb_pkg::*;
#(
    parameter int          NUM_REGS = 8,
    parameter logic [31:0] ID_VALUE = APB_ID_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [APB_IDX_W-1:0] wr_idx,
    input  logic [31:0]          wr_data,
    input  logic [APB_IDX_W-1:0] rd_idx,
    output logic [31:0]          rd_data,
    output logic [31:0]          reg0
);

    localparam int NW = NUM_REGS - 1;

    logic [NW-1:0][31:0] regs_q;
    logic [NW-1:0][31:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            for (int i = 0; i < NW; i++) begin
                if (wr_idx == APB_IDX_W'(i)) begin
                    regs_d[i] = wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx == APB_IDX_W'(NW)) begin
            rd_data = ID_VALUE;
        end
        for (int i = 0; i < NW; i++) begin
            if (rd_idx == APB_IDX_W'(i)) begin
                rd_data = regs_q[i];
            end
        end
    end

    assign reg0 = regs_q[0];

endmodule

// File: rtl/apb_slave_regs.sv
// rtl/apb_slave_regs.sv - APB completer: setup/access FSM, wait-state counter, decode and error response
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = APB_ID_DEFAULT
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [31:0] ctrl_out
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("apb_slave_regs: WAIT_CYCLES must be in 0..15");
    end
    if (NUM_REGS < 2 || NUM_REGS > 1024) begin : g_bad_regs
        $error("apb_slave_regs: NUM_REGS must be in 2..1024");
    end

    localparam logic [APB_DEC_W-1:0] REG_ID   = reg_id_offset(NUM_REGS);
    localparam logic [APB_IDX_W-1:0] LAST_IDX = APB_IDX_W'(NUM_REGS - 1);
    localparam logic [APB_CNT_W-1:0] WAIT_LD  = APB_CNT_W'(WAIT_CYCLES);

    apb_state_e           state_q, state_d;
    logic [APB_CNT_W-1:0] cnt_q,   cnt_d;
    logic [APB_DEC_W-1:0] addr_q,  addr_d;
    logic                 write_q, write_d;

    logic [APB_IDX_W-1:0] idx;
    logic                 dec_err;
    logic                 done;
    logic                 wr_en;
    logic [31:0]          rd_data;
    logic                 unused_paddr_hi;

    assign unused_paddr_hi = ^paddr[31:APB_DEC_W];

    // Decode only ever looks at the address captured in the setup phase.
    assign idx     = addr_q[APB_DEC_W-1:APB_IDX_LSB];
    assign dec_err = (addr_q[APB_IDX_LSB-1:0] != '0) || (idx > LAST_IDX)
                   || (write_q && addr_q == REG_ID);
    assign done    = (state_q == ST_ACCESS) && psel && penable && (cnt_q == '0);
    assign wr_en   = done && write_q && !dec_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    state_d = ST_ACCESS;
                    cnt_d   = WAIT_LD;
                    addr_d  = paddr[APB_DEC_W-1:0];
                    write_d = pwrite;
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                end else if (penable) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
        end
    end

    apb_regbank #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_regbank (
        .clk     (hclk),
        .rst_n   (hresetn),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_data (pwdata),
        .rd_idx  (idx),
        .rd_data (rd_data),
        .reg0    (ctrl_out)
    );

    assign pready  = done;
    assign pslverr = done && dec_err;
    assign prdata  = (done && !dec_err && !write_q) ? rd_data : 32'h0;

endmodule

// File: tb/tb_apb_slave_regs.sv
// tb/tb_apb_slave_regs.sv - directed bench for apb_slave_regs with WAIT_CYCLES of 0, 2 and 3
module tb_apb_slave_regs;

    logic            hclk;
    logic            hresetn;
    logic [2:0]      psel;
    logic            penable;
    logic            pwrite;
    logic [31:0]     paddr;
    logic [31:0]     pwdata;
    logic [2:0][31:0] prdata_v;
    logic [2:0]      pready_v;
    logic [2:0]      pslverr_v;
    logic [2:0][31:0] ctrl_v;

    int n_checks = 0;
    int n_fail   = 0;

    apb_slave_regs #(.NUM_REGS(8), .WAIT_CYCLES(0)) u_w0 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]),
        .pslverr(pslverr_v[0]), .ctrl_out(ctrl_v[0])
    );
    apb_slave_regs #(.NUM_REGS(8), .WAIT_CYCLES(2)) u_w2 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]),
        .pslverr(pslverr_v[1]), .ctrl_out(ctrl_v[1])
    );
    apb_slave_regs #(.NUM_REGS(8), .WAIT_CYCLES(3)) u_w3 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]),
        .pslverr(pslverr_v[2]), .ctrl_out(ctrl_v[2])
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    // Starts a setup phase at once (caller is just past a rising edge) and
    // returns just past the completing edge with the bus idle.
    task automatic apb_xfer(input int sel, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic err, output int waits, output logic tout);
        psel      = 3'b000;
        psel[sel] = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = addr;
        pwdata    = wdata;
        @(posedge hclk);
        #1 penable = 1'b1;
        #1;
        waits = 0;
        while (pready_v[sel] !== 1'b1 && waits < 20) begin
            @(posedge hclk);
            #2;
            waits++;
        end
        tout  = (pready_v[sel] !== 1'b1);
        rdata = prdata_v[sel];
        err   = pslverr_v[sel];
        @(posedge hclk);
        #1;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; int w; logic to;
        hresetn = 1'b0; psel = '0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        #1;
        n_checks++; if (pready_v !== 3'b000) begin n_fail++; $display("FAIL reset_pready: got %b expected 000", pready_v); end
        n_checks++; if (pslverr_v !== 3'b000) begin n_fail++; $display("FAIL reset_pslverr: got %b expected 000", pslverr_v); end
        n_checks++; if (prdata_v !== '0) begin n_fail++; $display("FAIL reset_prdata: got %h expected 0", prdata_v); end
        n_checks++; if (ctrl_v !== '0) begin n_fail++; $display("FAIL reset_ctrl_out: got %h expected 0", ctrl_v); end
        repeat (3) @(posedge hclk);
        #1 hresetn = 1'b1;
        apb_xfer(0, 1'b0, 32'h00, 32'h0, rd, er, w, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL reset_read_timeout: got %b expected 0", to); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_read_data: got %h expected 00000000", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL reset_read_err: got %b expected 0", er); end
    endtask

    task automatic test_rw_nowait();
        logic [31:0] rd; logic er; int w; logic to;
        apb_xfer(0, 1'b1, 32'h08, 32'hDEAD_BEEF, rd, er, w, to);
        n_checks++; if (w !== 0 || to !== 1'b0) begin n_fail++; $display("FAIL w0_write_waits: got %0d expected 0", w); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL w0_write_err: got %b expected 0", er); end
        apb_xfer(0, 1'b0, 32'h08, 32'h0, rd, er, w, to);
        n_checks++; if (w !== 0 || to !== 1'b0) begin n_fail++; $display("FAIL w0_read_waits: got %0d expected 0", w); end
        n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL w0_read_data: got %h expected deadbeef", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL w0_read_err: got %b expected 0", er); end
        n_checks++; if (ctrl_v[0] !== 32'h0) begin n_fail++; $display("FAIL ctrl_before: got %h expected 0", ctrl_v[0]); end
        apb_xfer(0, 1'b1, 32'h00, 32'h1234_5678, rd, er, w, to);
        n_checks++; if (ctrl_v[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL ctrl_after: got %h expected 12345678", ctrl_v[0]); end
        n_checks++; if (ctrl_v[1] !== 32'h0) begin n_fail++; $display("FAIL ctrl_other_inst: got %h expected 0", ctrl_v[1]); end
    endtask

    task automatic test_wait2_id();
        logic [31:0] rd; logic er; int w; logic to;
        apb_xfer(1, 1'b0, 32'h1C, 32'h0, rd, er, w, to);
        n_checks++; if (w !== 2 || to !== 1'b0) begin n_fail++; $display("FAIL w2_waits: got %0d expected 2", w); end
        n_checks++; if (rd !== 32'hA5B0_0001) begin n_fail++; $display("FAIL w2_id_data: got %h expected a5b00001", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL w2_id_err: got %b expected 0", er); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int w; logic to;
        apb_xfer(0, 1'b1, 32'h1C, 32'h5555_AAAA, rd, er, w, to);
        n_checks++; if (er !== 1'b1 || w !== 0) begin n_fail++; $display("FAIL err_id_write: got err %b waits %0d expected err 1 waits 0", er, w); end
        apb_xfer(0, 1'b0, 32'h1C, 32'h0, rd, er, w, to);
        n_checks++; if (rd !== 32'hA5B0_0001 || er !== 1'b0) begin n_fail++; $display("FAIL err_id_unchanged: got %h/%b expected a5b00001/0", rd, er); end
        apb_xfer(0, 1'b0, 32'h40, 32'h0, rd, er, w, to);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_range_flag: got %b expected 1", er); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_range_data: got %h expected 0", rd); end
        apb_xfer(0, 1'b1, 32'h06, 32'hFFFF_FFFF, rd, er, w, to);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_misaligned_flag: got %b expected 1", er); end
        apb_xfer(0, 1'b0, 32'h04, 32'h0, rd, er, w, to);
        n_checks++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL err_misaligned_nowrite: got %h/%b expected 0/0", rd, er); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int w; logic to;
        apb_xfer(0, 1'b1, 32'h0C, 32'hA0A0_A0A0, rd, er, w, to);
        apb_xfer(0, 1'b0, 32'h0C, 32'h0, rd, er, w, to);
        n_checks++; if (w !== 0 || to !== 1'b0) begin n_fail++; $display("FAIL b2b_waits: got %0d expected 0", w); end
        n_checks++; if (rd !== 32'hA0A0_A0A0) begin n_fail++; $display("FAIL b2b_data: got %h expected a0a0a0a0", rd); end
    endtask

    task automatic test_penable_no_setup();
        logic [31:0] rd; logic er; int w; logic to;
        psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (pready_v[0] !== 1'b0) begin n_fail++; $display("FAIL nosetup_pready0: got %b expected 0", pready_v[0]); end
        @(posedge hclk); #1;
        n_checks++; if (pready_v[0] !== 1'b0) begin n_fail++; $display("FAIL nosetup_pready1: got %b expected 0", pready_v[0]); end
        psel = '0; penable = 1'b0; pwrite = 1'b0;
        @(posedge hclk); #1;
        apb_xfer(0, 1'b0, 32'h0C, 32'h0, rd, er, w, to);
        n_checks++; if (rd !== 32'hA0A0_A0A0) begin n_fail++; $display("FAIL nosetup_nowrite: got %h expected a0a0a0a0", rd); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er; int w; logic to;
        apb_xfer(2, 1'b1, 32'h00, 32'hCAFE_0000, rd, er, w, to);
        apb_xfer(2, 1'b1, 32'h04, 32'h1111_2222, rd, er, w, to);
        n_checks++; if (w !== 3 || to !== 1'b0) begin n_fail++; $display("FAIL w3_waits: got %0d expected 3", w); end
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h9999_9999;
        @(posedge hclk); #1 penable = 1'b1;
        #1;
        n_checks++; if (pready_v[2] !== 1'b0) begin n_fail++; $display("FAIL abort_wait_pready: got %b expected 0", pready_v[2]); end
        @(posedge hclk); #1 psel = '0; penable = 1'b0;
        #1;
        n_checks++; if (pready_v[2] !== 1'b0) begin n_fail++; $display("FAIL abort_drop_pready: got %b expected 0", pready_v[2]); end
        repeat (4) @(posedge hclk);
        #1;
        apb_xfer(2, 1'b0, 32'h04, 32'h0, rd, er, w, to);
        n_checks++; if (rd !== 32'h1111_2222) begin n_fail++; $display("FAIL abort_nowrite: got %h expected 11112222", rd); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er; int w; logic to;
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h7777_7777;
        @(posedge hclk); #1 penable = 1'b1;
        @(posedge hclk); #1 hresetn = 1'b0;
        #1;
        n_checks++; if (ctrl_v !== '0) begin n_fail++; $display("FAIL rst_mid_ctrl: got %h expected 0", ctrl_v); end
        n_checks++; if (pready_v !== 3'b000 || pslverr_v !== 3'b000) begin n_fail++; $display("FAIL rst_mid_handshake: got %b/%b expected 000/000", pready_v, pslverr_v); end
        n_checks++; if (prdata_v !== '0) begin n_fail++; $display("FAIL rst_mid_prdata: got %h expected 0", prdata_v); end
        psel = '0; penable = 1'b0;
        repeat (2) @(posedge hclk);
        #1 hresetn = 1'b1;
        psel = 3'b100; penable = 1'b1;
        repeat (2) @(posedge hclk);
        #1;
        n_checks++; if (pready_v[2] !== 1'b0) begin n_fail++; $display("FAIL rst_needs_setup: got %b expected 0", pready_v[2]); end
        psel = '0; penable = 1'b0;
        @(posedge hclk); #1;
        apb_xfer(2, 1'b0, 32'h04, 32'h0, rd, er, w, to);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_cleared_reg: got %h expected 0", rd); end
        apb_xfer(2, 1'b0, 32'h08, 32'h0, rd, er, w, to);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_lost_write: got %h expected 0", rd); end
        apb_xfer(0, 1'b0, 32'h08, 32'h0, rd, er, w, to);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_cleared_w0: got %h expected 0", rd); end
    endtask

    initial begin
        test_reset();
        test_rw_nowait();
        test_wait2_id();
        test_errors();
        test_back_to_back();
        test_penable_no_setup();
        test_abort();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
